// File: rtl/updown_pkg.sv
// Shared definitions for the up/down request arbiter slice.
//   state_t        - sequencing FSM encoding (IDLE 00, GRANT 01, APPLY 10)
//   DIR_UP/DIR_DOWN - meaning of a requester's dir bit
//   rr_index()     - modulo step used by the round-robin scan
package updown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        APPLY = 2'b10
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Requester index reached by stepping 'off' places past 'base',
    // wrapping around the requester ring of size n.
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick for the up/down request arbiter.
// Ports:
//   req     - request bits, one per requester
//   last    - index of the previous winner; the scan starts just after it
//   win     - one-hot winner (all zero when no request is set)
//   win_idx - binary index of the winner (0 when no request is set)
module rr_arbiter
    import updown_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] win,
    output logic [IDXW-1:0] win_idx
);

    logic found;
    int   cand;

    // Walk the ring starting one past the last winner; the last winner
    // itself is examined last, so it only wins again when it is alone.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = rr_index(int'(last), off, NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/updown_req_arbiter.sv
// Shared WIDTH-bit up/down counter with NREQ round-robin requesters.
// Each operation runs IDLE -> GRANT -> APPLY -> IDLE; the count changes on
// the edge leaving APPLY and done marks the first cycle showing it.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   req   - per-requester request level, held until its gnt pulse
//   dir   - per-requester direction (1 up, 0 down)
//   gnt   - one-hot grant pulse, high during the GRANT cycle
//   done  - one-cycle pulse aligned with the updated count
//   busy  - high during GRANT and APPLY
//   count - shared count value
//   wrap  - (only with UPDOWN_WRAP_FLAG_EN) pulses with done when the
//           update crossed the 0/max boundary, or was clamped there (SAT=1)
// SAT=0 wraps modulo 2^WIDTH; SAT=1 holds the count at 0 and at 2^WIDTH-1.
module updown_req_arbiter
    import updown_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  dir,
    output logic [NREQ-1:0]  gnt,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] count
`ifdef UPDOWN_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [WIDTH-1:0] CMAX = '1;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   last;
    logic [IDXW-1:0]   win_idx;
    logic [NREQ-1:0]   win;
    logic              dir_q;
    logic              at_limit;
    logic [WIDTH-1:0]  count_nxt;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req),
        .last    (last),
        .win     (win),
        .win_idx (win_idx)
    );

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: an operation always takes exactly three cycles, so
    // back-to-back requests naturally revisit IDLE between operations.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = GRANT;
            GRANT:   state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Candidate count for the APPLY edge. at_limit means the step would
    // leave the representable range: it wraps naturally or holds under SAT.
    always_comb begin
        at_limit = (dir_q == DIR_UP) ? (count == CMAX) : (count == '0);
        if (at_limit && (SAT != 0)) begin
            count_nxt = count;
        end else if (dir_q == DIR_UP) begin
            count_nxt = count + WIDTH'(1);
        end else begin
            count_nxt = count - WIDTH'(1);
        end
    end

    // Grant, winner bookkeeping and the count register. The winner and its
    // direction are captured on the edge into GRANT, so req/dir changes
    // during GRANT and APPLY have no effect on the operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt   <= '0;
            done  <= 1'b0;
            count <= '0;
            last  <= IDXW'(NREQ - 1);
            dir_q <= DIR_DOWN;
`ifdef UPDOWN_WRAP_FLAG_EN
            wrap  <= 1'b0;
`endif
        end else begin
            gnt  <= '0;
            done <= 1'b0;
`ifdef UPDOWN_WRAP_FLAG_EN
            wrap <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= win;
                        last  <= win_idx;
                        dir_q <= dir[win_idx];
                    end
                end
                APPLY: begin
                    count <= count_nxt;
                    done  <= 1'b1;
`ifdef UPDOWN_WRAP_FLAG_EN
                    wrap  <= at_limit;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_updown_req_arbiter.sv
// Directed bench for updown_req_arbiter: a wrapping instance (SAT=0) and a
// saturating instance (SAT=1), both NREQ=4, WIDTH=3.
module tb_updown_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req1, dir1, gnt1;
    logic [3:0] req2, dir2, gnt2;
    logic       done1, busy1, done2, busy2;
    logic [2:0] count1, count2;
`ifdef UPDOWN_WRAP_FLAG_EN
    logic       wrap1, wrap2;
`endif

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] dir;
        logic [3:0] gnt;
        logic [2:0] count;
        logic       wrap;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    updown_req_arbiter #(.NREQ(4), .WIDTH(3), .SAT(0)) dut_wrap (
        .clk   (clk),
        .rst   (rst),
        .req   (req1),
        .dir   (dir1),
        .gnt   (gnt1),
        .done  (done1),
        .busy  (busy1),
        .count (count1)
`ifdef UPDOWN_WRAP_FLAG_EN
        ,
        .wrap  (wrap1)
`endif
    );

    updown_req_arbiter #(.NREQ(4), .WIDTH(3), .SAT(1)) dut_sat (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .dir   (dir2),
        .gnt   (gnt2),
        .done  (done2),
        .busy  (busy2),
        .count (count2)
`ifdef UPDOWN_WRAP_FLAG_EN
        ,
        .wrap  (wrap2)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [3:0] r, input logic [3:0] d);
        if (sel) begin
            req2 = r;
            dir2 = d;
        end else begin
            req1 = r;
            dir1 = d;
        end
    endtask

    // One complete operation starting at a negedge with the DUT in IDLE.
    task automatic runOp(input bit sel, input logic [3:0] r, input logic [3:0] d,
                         input logic [3:0] egnt, input logic [2:0] ecnt,
                         input logic ewrap, input string tag);
        applyStimulus(sel, r, d);
        @(negedge clk);
        checkOutput({tag, " gnt"},  sel ? gnt2 : gnt1, 32'(egnt));
        checkOutput({tag, " busy grant"}, sel ? busy2 : busy1, 1);
        checkOutput({tag, " done grant"}, sel ? done2 : done1, 0);
        applyStimulus(sel, 4'b0000, 4'b0000);
        @(negedge clk);
        checkOutput({tag, " gnt apply"},  sel ? gnt2 : gnt1, 0);
        checkOutput({tag, " busy apply"}, sel ? busy2 : busy1, 1);
        @(negedge clk);
        checkOutput({tag, " done"},  sel ? done2 : done1, 1);
        checkOutput({tag, " count"}, sel ? count2 : count1, 32'(ecnt));
        checkOutput({tag, " busy idle"}, sel ? busy2 : busy1, 0);
        checkOutput({tag, " gnt idle"},  sel ? gnt2 : gnt1, 0);
`ifdef UPDOWN_WRAP_FLAG_EN
        checkOutput({tag, " wrap"}, sel ? wrap2 : wrap1, 32'(ewrap));
`else
        if (ewrap === 1'bx) $display("[TB] unexpected wrap expectation in %s", tag);
`endif
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                                input logic [2:0] c, input logic w, input string t);
        vec_t v;
        v.req = r; v.dir = d; v.gnt = g; v.count = c; v.wrap = w; v.tag = t;
        return v;
    endfunction

    initial begin
        rst  = 1'b1;
        req1 = '0; dir1 = '0;
        req2 = '0; dir2 = '0;

        // Single requester counting up from 0 through the 7 -> 0 wrap.
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd1, 1'b0, "up1"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd2, 1'b0, "up2"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd3, 1'b0, "up3"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd4, 1'b0, "up4"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd5, 1'b0, "up5"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd6, 1'b0, "up6"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd7, 1'b0, "up7"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd0, 1'b1, "upwrap"));
        // Down from 0 wraps to 7, then up from 7 wraps back to 0.
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0010, 3'd7, 1'b1, "downwrap"));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0001, 3'd0, 1'b1, "upwrap2"));
        // All four requesting: last winner was 0, so rotation starts at 1.
        vecs.push_back(mk(4'b1111, 4'b1111, 4'b0010, 3'd1, 1'b0, "rr1"));
        vecs.push_back(mk(4'b1111, 4'b1111, 4'b0100, 3'd2, 1'b0, "rr2"));
        vecs.push_back(mk(4'b1111, 4'b1111, 4'b1000, 3'd3, 1'b0, "rr3"));
        vecs.push_back(mk(4'b1111, 4'b1111, 4'b0001, 3'd4, 1'b0, "rr4"));
        vecs.push_back(mk(4'b1111, 4'b1111, 4'b0010, 3'd5, 1'b0, "rr5"));
        // Mixed: requester 0 up, requester 1 down, alternating.
        vecs.push_back(mk(4'b0011, 4'b0001, 4'b0001, 3'd6, 1'b0, "mix1"));
        vecs.push_back(mk(4'b0011, 4'b0001, 4'b0010, 3'd5, 1'b0, "mix2"));
        vecs.push_back(mk(4'b0011, 4'b0001, 4'b0001, 3'd6, 1'b0, "mix3"));
        vecs.push_back(mk(4'b0011, 4'b0001, 4'b0010, 3'd5, 1'b0, "mix4"));

        // Reset held for three cycles, then twenty idle cycles.
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset count", count1, 0);
        checkOutput("reset gnt",   gnt1, 0);
        checkOutput("reset busy",  busy1, 0);
        checkOutput("reset done",  done1, 0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle quiet", {count1, gnt1, busy1, done1}, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            runOp(1'b0, vecs[i].req, vecs[i].dir, vecs[i].gnt, vecs[i].count,
                  vecs[i].wrap, vecs[i].tag);
        end

        // A request withdrawn before the edge is never granted.
        req1 = 4'b0100; dir1 = 4'b0100;
        #2 req1 = 4'b0000;
        @(negedge clk);
        checkOutput("dropped busy",  busy1, 0);
        checkOutput("dropped gnt",   gnt1, 0);
        checkOutput("dropped count", count1, 5);

        // Asynchronous reset in the middle of APPLY with count 5.
        applyStimulus(1'b0, 4'b0001, 4'b0001);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        checkOutput("midop busy before", busy1, 1);
        checkOutput("midop count before", count1, 5);
        #2 rst = 1'b0;
        #1;
        checkOutput("midop count async", count1, 0);
        checkOutput("midop busy async",  busy1, 0);
        checkOutput("midop gnt async",   gnt1, 0);
        @(negedge clk);
        checkOutput("midop no done",    done1, 0);
        checkOutput("midop count held", count1, 0);
        rst = 1'b1;
        runOp(1'b0, 4'b1111, 4'b1111, 4'b0001, 3'd1, 1'b0, "post reset");

        // Saturating instance: clamps at 0 and at 7, but still grants/dones.
        runOp(1'b1, 4'b0001, 4'b0000, 4'b0001, 3'd0, 1'b1, "sat down1");
        runOp(1'b1, 4'b0001, 4'b0000, 4'b0001, 3'd0, 1'b1, "sat down2");
        for (int i = 0; i < 9; i++) begin
            runOp(1'b1, 4'b0001, 4'b0001, 4'b0001, (i < 7) ? 3'(i + 1) : 3'd7,
                  (i >= 7) ? 1'b1 : 1'b0, $sformatf("sat up%0d", i + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // gnt must stay one-hot or zero and never coincide with done.
    always @(negedge clk) begin
        if (rst) begin
            if (!$onehot0(gnt1) || (|gnt1 && done1) || !$onehot0(gnt2) || (|gnt2 && done2)) begin
                failed++;
                tests++;
                $display("[TB] FAIL invariant: gnt1=%b done1=%b gnt2=%b done2=%b, required one-hot gnt without done",
                         gnt1, done1, gnt2, done2);
            end
        end
    end

endmodule

// File: doc/updown_req_arbiter.md
Name: updown_req_arbiter

Overview:
- Shares one WIDTH-bit up/down count register between NREQ requesters.
- Each requester asks for a single increment or decrement; a round-robin arbiter picks one winner per operation.
- A small FSM sequences the operation: grant, apply, done.
- Sits in front of the shared counter datapath and replaces the direct ctrl-driven counting used in single-user counters.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 3, count register width
- SAT, 0, 0 = wrap modulo 2^WIDTH; 1 = saturate at 0 and 2^WIDTH-1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset; rst=0 resets immediately, independent of clk
- req  input  NREQ  per-requester request level; held until its gnt pulse
- dir  input  NREQ  per-requester direction, 1 = up, 0 = down; sampled in the grant cycle
- gnt  output  NREQ  one-hot grant pulse, one cycle wide
- done  output  1  one-cycle pulse when count has been updated
- busy  output  1  high while an operation is in flight (GRANT or APPLY)
- count  output  WIDTH  shared count value

Behaviour:
- Reset (rst=0), asynchronous:
  - count=0, gnt=0, done=0, busy=0
  - state=IDLE
  - round-robin pointer last=NREQ-1, so req[0] has highest priority after reset.
- FSM states: IDLE, GRANT, APPLY.
- IDLE:
  - If any req bit is high, go to GRANT on the next edge; otherwise stay.
  - busy=0 in IDLE.
- GRANT (one cycle):
  - Winner is the first set req bit scanning from last+1 upward, wrapping modulo NREQ.
  - gnt[winner]=1, registered, so it is visible during the GRANT cycle.
  - Latch win_idx and dir[winner]; set last=win_idx.
  - Next state is APPLY.
- APPLY (one cycle):
  - count <= count+1 if the latched dir=1, else count-1, both at WIDTH bits.
  - done=1 during the cycle after the update edge, i.e. aligned with the new count.
  - Next state is IDLE.
- Latency and throughput:
  - Request-to-updated-count latency is 3 edges.
  - At most one operation per 3 cycles.
  - Back-to-back requests always pass through IDLE.
- Wrap and saturation:
  - SAT=0: 2^WIDTH-1 +1 gives 0, and 0 -1 gives 2^WIDTH-1.
  - SAT=1: count holds at the limit; done still pulses and gnt is still issued.
- Request handling:
  - A requester dropping req before its grant is simply not granted; no error.
  - Changes to req or dir during GRANT/APPLY are ignored until the next IDLE.
- Reset mid-operation: any pending grant or update is discarded, and count returns to 0 with no done pulse.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt and done never assert in the same cycle.

Optional Feature:
- Macro: UPDOWN_WRAP_FLAG_EN.
- Defined:
  - Adds output wrap (1 bit), pulsed together with done when an APPLY crosses the boundary.
  - With SAT=0, a boundary crossing is max to 0, or 0 to max.
  - With SAT=1, wrap flags an attempted crossing that was clamped.
  - wrap resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package updown_pkg holds:
  - state typedef {IDLE, GRANT, APPLY} as 2-bit encoding 00/01/10
  - DIR_UP=1 and DIR_DOWN=0 constants
- One natural sub-module: rr_arbiter.
  - Purely combinational: inputs req and last, outputs one-hot winner and its index.
  - Lets the FSM and count register stay in the top.

Test Plan:
- Reset then idle: rst=0 for 3 cycles then 1, no req -> count=0, gnt=0, busy=0 for 20 cycles; asserting rst=0 between edges clears outputs immediately.
- Single requester up: req=0001, dir=0001 held -> gnt=0001 every 3 cycles, count 0,1,...,7,0 (wrap); done pulses every 3 cycles.
- Round-robin fairness: req=1111 held, dir=1111 -> gnt order 0001, 0010, 0100, 1000, 0001; count increments by 1 each done.
- Mixed directions: req=0011, dir=0001 -> alternating +1/-1, count toggles 1,0,1,0; with SAT=0 and start 0 down first, count goes 7 (wrap flag pulses if UPDOWN_WRAP_FLAG_EN).
- Saturation: SAT=1, req=0001, dir=0000 from count=0 -> count stays 0, gnt and done keep pulsing; up 9 times -> count stops at 7.
- Reset mid-op: rst=0 asynchronously during APPLY with count=5 -> count=0 immediately, no done, FSM IDLE; next grant goes to req[0] first.
